// File: rtl/frame_link_ctrl.sv
// UART frame link controller: receives a sync-framed pixel packet, writes the ifmap,
// launches inference and returns the predicted class (or an error byte) over UART.
module frame_link_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int FRAC_BITS      = 7,
   parameter int IMG_SIZE       = 28,
   parameter int IN_CHANNELS    = 1,
   parameter int NUM_CLASSES    = 10,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                                                 clk,
   input  logic                                                 reset,
   input  logic                                                 rx_dv,
   input  logic [7:0]                                           rx_byte,
   output logic                                                 tx_dv,
   output logic [7:0]                                           tx_byte,
   input  logic                                                 tx_busy,
   output logic                                                 pix_we,
   output logic [((IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1)-1:0] pix_ch,
   output logic [$clog2(IMG_SIZE)-1:0]                          pix_row,
   output logic [$clog2(IMG_SIZE)-1:0]                          pix_col,
   output logic signed [DATA_WIDTH-1:0]                         pix_data,
   output logic                                                 frame_loaded,
   input  logic                                                 result_valid,
   input  logic [((NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1)-1:0] result_idx,
   output logic                                                 err_checksum,
   output logic                                                 err_timeout,
   output logic                                                 err_overrun,
   output logic [15:0]                                          frame_count,
   output logic                                                 busy
);

   localparam int N    = IN_CHANNELS * IMG_SIZE * IMG_SIZE;
   localparam int CHW  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
   localparam int PW   = $clog2(IMG_SIZE);
   localparam int CW   = $clog2(N + 1);
   localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [CW-1:0]  N_CNT    = CW'(N);
   localparam logic [PW-1:0]  LAST_POS = PW'(IMG_SIZE - 1);
   localparam logic [CHW-1:0] LAST_CH  = CHW'(IN_CHANNELS - 1);
   // Fire on the edge where the counter steps onto TIMEOUT_CYCLES-1, so the pulse
   // appears TIMEOUT_CYCLES-1 cycles after the last received byte.
   localparam logic [TW-1:0]  TMO_FIRE = TW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_RECV, S_CHECK, S_WAIT_RESULT, S_TX_REQ, S_TX_WAIT
   } state_t;

   state_t state, state_nxt;

   logic [CHW-1:0] ch_cnt;
   logic [PW-1:0]  row_cnt, col_cnt;
   logic [CW-1:0]  pix_cnt;
   logic [7:0]     xor_acc;
   logic [7:0]     chk_byte;
   logic [TW-1:0]  tmo_cnt;
   logic [7:0]     q0, q1;
   logic [1:0]     q_cnt;
   logic           tx_first;

   logic start_frame, pix_wr, chk_take, frame_ok, frame_bad;
   logic tmo_fire, overrun, res_take, tx_issue;

   function automatic logic signed [DATA_WIDTH-1:0] to_fixed(input logic [7:0] b);
      logic signed [DATA_WIDTH-1:0] ext;
      ext      = $signed({{(DATA_WIDTH-8){1'b0}}, b});
      to_fixed = ext <<< FRAC_BITS;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      pix_wr      = 1'b0;
      chk_take    = 1'b0;
      frame_ok    = 1'b0;
      frame_bad   = 1'b0;
      tmo_fire    = 1'b0;
      overrun     = 1'b0;
      res_take    = 1'b0;
      tx_issue    = 1'b0;
      case (state)
         S_IDLE: begin
            if (rx_dv && rx_byte == 8'hA5) begin
               start_frame = 1'b1;
               state_nxt   = S_RECV;
            end
         end
         S_RECV: begin
            // A byte arriving in the expiry cycle takes precedence over the timeout.
            if (rx_dv) begin
               if (pix_cnt == N_CNT) begin
                  chk_take  = 1'b1;
                  state_nxt = S_CHECK;
               end else begin
                  pix_wr = 1'b1;
               end
            end else if (tmo_cnt == TMO_FIRE) begin
               tmo_fire  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_CHECK: begin
            overrun = rx_dv;
            if (chk_byte == xor_acc) begin
               frame_ok  = 1'b1;
               state_nxt = S_WAIT_RESULT;
            end else begin
               frame_bad = 1'b1;
               state_nxt = S_TX_REQ;
            end
         end
         S_WAIT_RESULT: begin
            overrun = rx_dv;
            if (result_valid) begin
               res_take  = 1'b1;
               state_nxt = S_TX_REQ;
            end
         end
         S_TX_REQ: begin
            overrun = rx_dv;
            if (!tx_busy) begin
               tx_issue  = 1'b1;
               state_nxt = S_TX_WAIT;
            end
         end
         S_TX_WAIT: begin
            overrun = rx_dv;
            // uart_tx may not raise busy until the cycle after tx_dv.
            if (!tx_first && !tx_busy)
               state_nxt = (q_cnt != 2'd0) ? S_TX_REQ : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_we       <= 1'b0;
         frame_loaded <= 1'b0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
         tx_dv        <= 1'b0;
         tx_first     <= 1'b0;
         tx_byte      <= 8'h00;
         pix_ch       <= '0;
         pix_row      <= '0;
         pix_col      <= '0;
         ch_cnt       <= '0;
         row_cnt      <= '0;
         col_cnt      <= '0;
         pix_cnt      <= '0;
         xor_acc      <= 8'h00;
         tmo_cnt      <= '0;
         frame_count  <= 16'h0000;
         q_cnt        <= 2'd0;
      end else begin
         pix_we       <= pix_wr;
         frame_loaded <= frame_ok;
         err_checksum <= frame_bad;
         err_timeout  <= tmo_fire;
         err_overrun  <= overrun;
         tx_dv        <= tx_issue;
         tx_first     <= tx_issue;

         if (start_frame || rx_dv) tmo_cnt <= '0;
         else if (state == S_RECV) tmo_cnt <= tmo_cnt + 1'b1;

         if (start_frame) begin
            ch_cnt  <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            pix_cnt <= '0;
            xor_acc <= 8'h00;
         end else if (pix_wr) begin
            pix_ch  <= ch_cnt;
            pix_row <= row_cnt;
            pix_col <= col_cnt;
            pix_cnt <= pix_cnt + 1'b1;
            xor_acc <= xor_acc ^ rx_byte;
            if (col_cnt == LAST_POS) begin
               col_cnt <= '0;
               if (row_cnt == LAST_POS) begin
                  row_cnt <= '0;
                  ch_cnt  <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
               end else begin
                  row_cnt <= row_cnt + 1'b1;
               end
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end

         if (frame_ok) frame_count <= frame_count + 16'd1;

         if (frame_bad)      q_cnt <= 2'd1;
         else if (res_take)  q_cnt <= 2'd2;
         else if (tx_issue) begin
            q_cnt   <= q_cnt - 2'd1;
            tx_byte <= q0;
         end
      end
   end

   // Data-only registers: no reset needed, qualified by the control strobes above.
   always_ff @(posedge clk) begin
      if (pix_wr)   pix_data <= to_fixed(rx_byte);
      if (chk_take) chk_byte <= rx_byte;
      if (frame_bad) begin
         q0 <= 8'h45;
      end else if (res_take) begin
         q0 <= 8'h30 + 8'(result_idx);
         q1 <= 8'h0A;
      end else if (tx_issue) begin
         q0 <= q1;
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_frame_link_ctrl.sv
// Directed bench for frame_link_ctrl with a 2x4x4 frame, 100-cycle timeout and a simple uart_tx busy model.
module tb_frame_link_ctrl;

   logic              clk = 1'b0;
   logic              reset;
   logic              rx_dv;
   logic [7:0]        rx_byte;
   logic              tx_dv;
   logic [7:0]        tx_byte;
   logic              tx_busy;
   logic              pix_we;
   logic [0:0]        pix_ch;
   logic [1:0]        pix_row, pix_col;
   logic signed [15:0] pix_data;
   logic              frame_loaded;
   logic              result_valid;
   logic [3:0]        result_idx;
   logic              err_checksum, err_timeout, err_overrun;
   logic [15:0]       frame_count;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;

   int n_we = 0, n_fl = 0, n_ecs = 0, n_eto = 0, n_eov = 0, n_tx = 0;
   int n_txviol = 0, n_unstable = 0;
   logic [20:0] pix_log [0:511];
   logic [7:0]  tx_log  [0:63];
   logic [7:0]  held_byte = 8'h00;
   bit          holding = 1'b0;
   int          busy_cnt = 0;
   logic        model_busy = 1'b0;
   logic        force_busy;

   assign tx_busy = model_busy | force_busy;

   frame_link_ctrl #(
      .DATA_WIDTH(16), .FRAC_BITS(7), .IMG_SIZE(4), .IN_CHANNELS(2),
      .NUM_CLASSES(10), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .reset(reset), .rx_dv(rx_dv), .rx_byte(rx_byte),
      .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_busy(tx_busy),
      .pix_we(pix_we), .pix_ch(pix_ch), .pix_row(pix_row), .pix_col(pix_col),
      .pix_data(pix_data), .frame_loaded(frame_loaded),
      .result_valid(result_valid), .result_idx(result_idx),
      .err_checksum(err_checksum), .err_timeout(err_timeout), .err_overrun(err_overrun),
      .frame_count(frame_count), .busy(busy)
   );

   always #5 clk = ~clk;

   // Event monitor and uart_tx busy model, sampled on the falling edge.
   always @(negedge clk) begin
      if (pix_we) begin
         if (n_we < 512) pix_log[n_we] = {pix_ch, pix_row, pix_col, pix_data};
         n_we++;
      end
      if (frame_loaded) n_fl++;
      if (err_checksum) n_ecs++;
      if (err_timeout)  n_eto++;
      if (err_overrun)  n_eov++;
      if (tx_dv) begin
         if (n_tx < 64) tx_log[n_tx] = tx_byte;
         n_tx++;
         if (tx_busy) n_txviol++;
         held_byte = tx_byte;
         holding   = 1'b1;
      end else if (holding) begin
         if (tx_byte !== held_byte) n_unstable++;
         if (!busy) holding = 1'b0;
      end
      if (tx_dv) busy_cnt = 4;
      else if (busy_cnt > 0) busy_cnt--;
      model_busy = (busy_cnt > 0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_byte = b;
      @(negedge clk);
      rx_dv   = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] chk);
      send_byte(8'hA5);
      for (int i = 0; i < 32; i++) send_byte(8'(i));
      send_byte(chk);
   endtask

   task automatic pulse_result(input logic [3:0] idx);
      @(negedge clk);
      result_valid = 1'b1;
      result_idx   = idx;
      @(negedge clk);
      result_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_idle: busy=%0b after %0d cycles, want 0", tag, busy, k);
      end
   endtask

   task automatic check_quiet_outputs(input string tag);
      n_cmp++;
      if ({busy, tx_dv, pix_we, frame_loaded, err_checksum, err_timeout, err_overrun} !== 7'b0) begin
         n_bad++;
         $display("FAIL %s_ctrl: busy,tx_dv,pix_we,fl,ecs,eto,eov=%b want 0000000", tag,
                  {busy, tx_dv, pix_we, frame_loaded, err_checksum, err_timeout, err_overrun});
      end
      n_cmp++;
      if ({pix_ch, pix_row, pix_col} !== 5'b0) begin
         n_bad++;
         $display("FAIL %s_addr: ch/row/col=%b want 00000", tag, {pix_ch, pix_row, pix_col});
      end
      n_cmp++;
      if (tx_byte !== 8'h00) begin
         n_bad++;
         $display("FAIL %s_tx_byte: got %h want 00", tag, tx_byte);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
      result_valid = 1'b0; result_idx = 4'd0; force_busy = 1'b0;
      repeat (3) @(negedge clk);
      check_quiet_outputs("reset");
      n_cmp++;
      if (frame_count !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_frame_count: got %0d want 0", frame_count);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_frame();
      int we0, fl0;
      we0 = n_we; fl0 = n_fl;
      send_frame(8'h00);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (n_we - we0 !== 32) begin
         n_bad++; $display("FAIL good_we_count: got %0d want 32", n_we - we0);
      end
      n_cmp++;
      if (pix_log[we0 + 5] !== {1'b0, 2'd1, 2'd1, 16'h0280}) begin
         n_bad++; $display("FAIL good_pix5: got %h want %h", pix_log[we0 + 5], {1'b0, 2'd1, 2'd1, 16'h0280});
      end
      n_cmp++;
      if (pix_log[we0 + 16] !== {1'b1, 2'd0, 2'd0, 16'h0800}) begin
         n_bad++; $display("FAIL good_pix16: got %h want %h", pix_log[we0 + 16], {1'b1, 2'd0, 2'd0, 16'h0800});
      end
      n_cmp++;
      if (pix_log[we0 + 31] !== {1'b1, 2'd3, 2'd3, 16'h0F80}) begin
         n_bad++; $display("FAIL good_pix31: got %h want %h", pix_log[we0 + 31], {1'b1, 2'd3, 2'd3, 16'h0F80});
      end
      n_cmp++;
      if (n_fl - fl0 !== 1) begin
         n_bad++; $display("FAIL good_frame_loaded: got %0d pulses want 1", n_fl - fl0);
      end
      n_cmp++;
      if (frame_count !== 16'd1) begin
         n_bad++; $display("FAIL good_frame_count: got %0d want 1", frame_count);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++; $display("FAIL good_wait_busy: got %0b want 1", busy);
      end
   endtask

   task automatic test_result_tx();
      int tx0;
      tx0 = n_tx;
      force_busy = 1'b1;
      pulse_result(4'd7);
      repeat (6) @(negedge clk);
      n_cmp++;
      if (n_tx - tx0 !== 0) begin
         n_bad++; $display("FAIL result_held_by_busy: got %0d tx want 0", n_tx - tx0);
      end
      force_busy = 1'b0;
      wait_idle("result");
      n_cmp++;
      if (n_tx - tx0 !== 2) begin
         n_bad++; $display("FAIL result_tx_count: got %0d want 2", n_tx - tx0);
      end
      n_cmp++;
      if ({tx_log[tx0], tx_log[tx0 + 1]} !== 16'h370A) begin
         n_bad++; $display("FAIL result_tx_bytes: got %h%h want 370a", tx_log[tx0], tx_log[tx0 + 1]);
      end
   endtask

   task automatic test_result_ignored();
      int tx0;
      tx0 = n_tx;
      pulse_result(4'd5);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || n_tx - tx0 !== 0) begin
         n_bad++; $display("FAIL idle_result_ignored: busy=%0b tx=%0d want 0/0", busy, n_tx - tx0);
      end
   endtask

   task automatic test_bad_checksum();
      int fl0, ecs0, tx0;
      fl0 = n_fl; ecs0 = n_ecs; tx0 = n_tx;
      send_frame(8'h01);
      wait_idle("badchk");
      n_cmp++;
      if (n_ecs - ecs0 !== 1) begin
         n_bad++; $display("FAIL badchk_err: got %0d pulses want 1", n_ecs - ecs0);
      end
      n_cmp++;
      if (n_fl - fl0 !== 0) begin
         n_bad++; $display("FAIL badchk_no_load: got %0d pulses want 0", n_fl - fl0);
      end
      n_cmp++;
      if (n_tx - tx0 !== 1 || tx_log[tx0] !== 8'h45) begin
         n_bad++; $display("FAIL badchk_tx: got %0d bytes first %h want 1 x 45", n_tx - tx0, tx_log[tx0]);
      end
      n_cmp++;
      if (frame_count !== 16'd1) begin
         n_bad++; $display("FAIL badchk_frame_count: got %0d want 1", frame_count);
      end
   endtask

   task automatic test_timeout();
      int fl0, tx0, n;
      fl0 = n_fl; tx0 = n_tx;
      send_byte(8'hA5);
      for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
      n = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (err_timeout) begin n = k; break; end
      end
      n_cmp++;
      if (n !== 99) begin
         n_bad++; $display("FAIL timeout_latency: got %0d cycles want 99", n);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || n_fl - fl0 !== 0 || n_tx - tx0 !== 0) begin
         n_bad++; $display("FAIL timeout_abort: busy=%0b fl=%0d tx=%0d want 0/0/0", busy, n_fl - fl0, n_tx - tx0);
      end
      send_frame(8'h00);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (n_fl - fl0 !== 1 || frame_count !== 16'd2) begin
         n_bad++; $display("FAIL timeout_recover: fl=%0d count=%0d want 1/2", n_fl - fl0, frame_count);
      end
   endtask

   task automatic test_overrun();
      int we0, eov0, tx0;
      we0 = n_we; eov0 = n_eov; tx0 = n_tx;
      send_byte(8'h11);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (n_eov - eov0 !== 1) begin
         n_bad++; $display("FAIL overrun_err: got %0d pulses want 1", n_eov - eov0);
      end
      n_cmp++;
      if (n_we - we0 !== 0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL overrun_no_write: we=%0d busy=%0b want 0/1", n_we - we0, busy);
      end
      pulse_result(4'd3);
      wait_idle("overrun");
      n_cmp++;
      if (n_tx - tx0 !== 2 || {tx_log[tx0], tx_log[tx0 + 1]} !== 16'h330A) begin
         n_bad++; $display("FAIL overrun_tx: got %0d bytes %h%h want 2 x 330a", n_tx - tx0, tx_log[tx0], tx_log[tx0 + 1]);
      end
   endtask

   task automatic test_reset_mid_recv();
      int fl0;
      fl0 = n_fl;
      send_byte(8'hA5);
      for (int i = 0; i < 10; i++) send_byte(8'(i));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_quiet_outputs("midreset");
      n_cmp++;
      if (frame_count !== 16'd0) begin
         n_bad++; $display("FAIL midreset_frame_count: got %0d want 0", frame_count);
      end
      reset = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (n_fl - fl0 !== 0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL midreset_no_load: fl=%0d busy=%0b want 0/0", n_fl - fl0, busy);
      end
   endtask

   task automatic test_leading_garbage();
      int fl0, e0, tx0;
      fl0 = n_fl; e0 = n_ecs + n_eto + n_eov; tx0 = n_tx;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_frame(8'h00);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (n_ecs + n_eto + n_eov - e0 !== 0) begin
         n_bad++; $display("FAIL garbage_errors: got %0d error pulses want 0", n_ecs + n_eto + n_eov - e0);
      end
      n_cmp++;
      if (n_fl - fl0 !== 1 || frame_count !== 16'd1) begin
         n_bad++; $display("FAIL garbage_accept: fl=%0d count=%0d want 1/1", n_fl - fl0, frame_count);
      end
      pulse_result(4'd0);
      wait_idle("garbage");
      n_cmp++;
      if (n_tx - tx0 !== 2 || {tx_log[tx0], tx_log[tx0 + 1]} !== 16'h300A) begin
         n_bad++; $display("FAIL garbage_tx: got %0d bytes %h%h want 2 x 300a", n_tx - tx0, tx_log[tx0], tx_log[tx0 + 1]);
      end
   endtask

   task automatic test_tx_protocol();
      n_cmp++;
      if (n_txviol !== 0) begin
         n_bad++; $display("FAIL tx_while_busy: got %0d issues want 0", n_txviol);
      end
      n_cmp++;
      if (n_unstable !== 0) begin
         n_bad++; $display("FAIL tx_byte_stable: got %0d changes want 0", n_unstable);
      end
   endtask

   initial begin
      test_reset();
      test_result_ignored();
      test_good_frame();
      test_result_tx();
      test_bad_checksum();
      test_timeout();
      test_overrun();
      test_reset_mid_recv();
      test_leading_garbage();
      test_tx_protocol();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
